// File: rtl/clk_seq_pkg.sv
// Shared types and helpers for the clock-enable sequencer.
// The state encoding is visible on the debug port, so the enum values are fixed.
package clk_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } seq_state_t;

  // Index of the highest set bit; an all-zero vector returns 0.
  function automatic logic [4:0] thermo_top(input logic [31:0] v);
    logic [4:0] top;
    top = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) top = 5'(i);
    end
    return top;
  endfunction

endpackage

// File: rtl/seq_step_timer.sv
// Step-delay timer: tick is high for one cycle out of every dly+1 cycles.
// load restarts the count and captures a new delay value.
module seq_step_timer #(
  parameter int DLY_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DLY_W-1:0] dly,
  output logic             tick
);

  logic [DLY_W-1:0] r_cnt;
  logic [DLY_W-1:0] r_dly;
  logic             w_hit;

  // Equality compare only, so the counter never needs to wrap.
  assign w_hit = (r_cnt == r_dly);
  assign tick  = w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_dly <= '0;
    end else if (load) begin
      r_cnt <= '0;
      r_dly <= dly;
    end else if (w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clk_ena_sequencer.sv
// Powers N_CH clock enables up one at a time in ascending order, and powers them
// down in reverse order. Each step is separated by a programmable delay.
module clk_ena_sequencer
  import clk_seq_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DLY_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DLY_W-1:0] step_dly,
  output logic [N_CH-1:0]  ena,
  output logic             busy,
  output logic             up_done,
  output logic             down_done,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_CH - 1);

  // start and stop are single-cycle requests with no handshake back. A request
  // the current state cannot use is dropped and never queued. When both are
  // high in the same cycle, stop takes priority.
  seq_state_t      r_state;
  seq_state_t      w_state_nxt;
  logic [N_CH-1:0] r_ena;
  logic [N_CH-1:0] w_ena_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic            r_busy;
  logic            w_busy_nxt;
  logic            r_up_done;
  logic            w_up_done_nxt;
  logic            r_down_done;
  logic            w_down_done_nxt;
  logic            w_load;
  logic            w_tick;
  logic            w_start_ok;
  logic            w_none_on;
  logic [IDX_W-1:0] w_top;

  assign w_start_ok = start & ~stop;
  assign w_none_on  = (r_ena == '0);
  assign w_top      = IDX_W'(thermo_top(32'(r_ena)));

  seq_step_timer #(
    .DLY_W (DLY_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .dly  (step_dly),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ena       <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_up_done   <= 1'b0;
      r_down_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ena       <= w_ena_nxt;
      r_idx       <= w_idx_nxt;
      r_busy      <= w_busy_nxt;
      r_up_done   <= w_up_done_nxt;
      r_down_done <= w_down_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start_ok) w_state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        // An abort before any channel is on goes straight back to IDLE.
        if (stop) w_state_nxt = w_none_on ? IDLE : RAMP_DOWN;
        else if (w_tick && (r_idx == IDX_TOP)) w_state_nxt = ON;
      end
      ON: begin
        if (stop) w_state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (w_tick && (r_idx == '0)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ena_nxt       = r_ena;
    w_idx_nxt       = r_idx;
    w_busy_nxt      = r_busy;
    w_up_done_nxt   = 1'b0;
    w_down_done_nxt = 1'b0;
    w_load          = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ena_nxt = '0;
        if (w_start_ok) begin
          w_load     = 1'b1;
          w_idx_nxt  = '0;
          w_busy_nxt = 1'b1;
        end
      end
      RAMP_UP: begin
        if (stop) begin
          w_load = 1'b1;
          if (w_none_on) begin
            w_idx_nxt       = '0;
            w_busy_nxt      = 1'b0;
            w_down_done_nxt = 1'b1;
          end else begin
            w_idx_nxt = w_top;
          end
        end else if (w_tick) begin
          w_ena_nxt[r_idx] = 1'b1;
          if (r_idx == IDX_TOP) begin
            w_busy_nxt    = 1'b0;
            w_up_done_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      ON: begin
        if (stop) begin
          w_load     = 1'b1;
          w_idx_nxt  = IDX_TOP;
          w_busy_nxt = 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (w_tick) begin
          w_ena_nxt[r_idx] = 1'b0;
          if (r_idx == '0) begin
            w_busy_nxt      = 1'b0;
            w_down_done_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx - 1'b1;
          end
        end
      end
      default: begin
        w_ena_nxt  = '0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign ena       = r_ena;
  assign busy      = r_busy;
  assign up_done   = r_up_done;
  assign down_done = r_down_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_clk_ena_sequencer.sv
// Bench for clk_ena_sequencer: directed timing scenarios plus randomized start/stop,
// all checked every cycle against a schedule-based reference model.
module tb_clk_ena_sequencer;

  localparam int N     = 4;
  localparam int DLY_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [DLY_W-1:0] step_dly = '0;
  logic [N-1:0]     ena;
  logic             busy;
  logic             up_done;
  logic             down_done;
  logic [1:0]       dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  clk_ena_sequencer #(
    .N_CH  (N),
    .DLY_W (DLY_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .step_dly  (step_dly),
    .ena       (ena),
    .busy      (busy),
    .up_done   (up_done),
    .down_done (down_done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  // Reference model: mode 0..3 = idle/up/on/down; ena level follows directly
  // from elapsed edges since the accepted command divided by (delay+1).
  int     m_mode = 0;
  int     m_level = 0;
  int     m_base = 0;
  longint m_t0 = 0;
  longint m_period = 1;
  bit     m_busy = 0;
  bit     m_up = 0;
  bit     m_dn = 0;

  always @(posedge clk) begin
    cyc++;
    m_up = 0;
    m_dn = 0;
    if (rst) begin
      m_mode  = 0;
      m_level = 0;
      m_busy  = 0;
    end else begin
      case (m_mode)
        0: if (start && !stop) begin
          m_mode = 1; m_t0 = cyc; m_period = longint'(step_dly) + 1; m_busy = 1;
        end
        1: if (stop) begin
          m_t0 = cyc; m_period = longint'(step_dly) + 1;
          if (m_level == 0) begin
            m_mode = 0; m_dn = 1; m_busy = 0;
          end else begin
            m_mode = 3; m_base = m_level;
          end
        end else begin
          m_level = int'((longint'(cyc) - m_t0) / m_period);
          if (m_level == N) begin
            m_mode = 2; m_up = 1; m_busy = 0;
          end
        end
        2: if (stop) begin
          m_mode = 3; m_t0 = cyc; m_base = N; m_period = longint'(step_dly) + 1; m_busy = 1;
        end
        default: begin
          m_level = m_base - int'((longint'(cyc) - m_t0) / m_period);
          if (m_level == 0) begin
            m_mode = 0; m_dn = 1; m_busy = 0;
          end
        end
      endcase
    end
  end

  logic [N-1:0] prev_ena = '0;
  logic         prev_up = 1'b0;
  logic         prev_dn = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0] exp_ena;
    logic [N:0]   t;
    if (rst) begin
      chk("rst_ena", 64'(ena), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
    end else begin
      exp_ena = N'((1 << m_level) - 1);
      t = {1'b0, ena} + 1'b1;
      chk("model_ena", 64'(ena), 64'(exp_ena));
      chk("model_busy", 64'(busy), 64'(m_busy));
      chk("model_up_done", 64'(up_done), 64'(m_up));
      chk("model_down_done", 64'(down_done), 64'(m_dn));
      chk("model_state", 64'(dbg_state), 64'(m_mode));
      chk("thermo", 64'((t[N-1:0] & ena) == '0), 64'(1));
      chk("one_bit_step", 64'($countones(ena ^ prev_ena) <= 1), 64'(1));
      chk("up_done_width", 64'(up_done && prev_up), 64'(0));
      chk("down_done_width", 64'(down_done && prev_dn), 64'(0));
    end
    prev_ena = ena;
    prev_up  = up_done;
    prev_dn  = down_done;
  end

  task automatic check_at(input int target, input string name, input logic [N-1:0] exp_ena);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
    chk(name, 64'(ena), 64'(exp_ena));
  endtask

  // Drives a one-cycle request that is sampled at edge number target.
  task automatic cmd_at(input int target, input logic s, input logic p, input logic [DLY_W-1:0] d);
    while (cyc < target - 1) begin
      @(posedge clk);
      #1;
    end
    start = s;
    stop = p;
    step_dly = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ena", 64'(ena), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_up_done", 64'(up_done), 64'(0));
    chk("reset_down_done", 64'(down_done), 64'(0));
    chk("reset_state", 64'(dbg_state), 64'(0));
    rst = 1'b0;

    // Ramp up with delay 2.
    cmd_at(cyc + 3, 1'b1, 1'b0, 16'd2);
    k = cyc;
    chk("up_busy_rise", 64'(busy), 64'(1));
    check_at(k + 3, "up_0001", 4'b0001);
    check_at(k + 6, "up_0011", 4'b0011);
    check_at(k + 9, "up_0111", 4'b0111);
    check_at(k + 11, "up_hold", 4'b0111);
    chk("up_busy_mid", 64'(busy), 64'(1));
    check_at(k + 12, "up_1111", 4'b1111);
    chk("up_done_pulse", 64'(up_done), 64'(1));
    chk("up_busy_fall", 64'(busy), 64'(0));
    check_at(k + 13, "on_1111", 4'b1111);
    chk("up_done_clear", 64'(up_done), 64'(0));

    // Ramp down with delay 0.
    cmd_at(k + 20, 1'b0, 1'b1, 16'd0);
    k = cyc;
    check_at(k + 1, "dn_0111", 4'b0111);
    check_at(k + 2, "dn_0011", 4'b0011);
    check_at(k + 3, "dn_0001", 4'b0001);
    check_at(k + 4, "dn_0000", 4'b0000);
    chk("dn_done_pulse", 64'(down_done), 64'(1));
    check_at(k + 5, "dn_idle", 4'b0000);
    chk("dn_idle_state", 64'(dbg_state), 64'(0));

    // Abort during ramp-up with two channels on.
    cmd_at(cyc + 3, 1'b1, 1'b0, 16'd3);
    k = cyc;
    cmd_at(k + 9, 1'b0, 1'b1, 16'd3);
    chk("abort_at_stop", 64'(ena), 64'(4'b0011));
    check_at(k + 13, "abort_0001", 4'b0001);
    check_at(k + 17, "abort_0000", 4'b0000);
    chk("abort_down_done", 64'(down_done), 64'(1));

    // start and stop together in IDLE are ignored.
    cmd_at(cyc + 2, 1'b1, 1'b1, 16'd5);
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("both_ena", 64'(ena), 64'(0));
      chk("both_busy", 64'(busy), 64'(0));
    end

    // Asynchronous reset mid-ramp, then restart from channel 0.
    cmd_at(cyc + 2, 1'b1, 1'b0, 16'd1);
    k = cyc;
    check_at(k + 7, "pre_rst_0111", 4'b0111);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ena", 64'(ena), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmd_at(cyc + 2, 1'b1, 1'b0, 16'd0);
    k = cyc;
    check_at(k + 1, "restart_0001", 4'b0001);
    check_at(k + 4, "restart_1111", 4'b1111);

    // Maximum delay, aborted before any channel turns on.
    cmd_at(cyc + 2, 1'b0, 1'b1, 16'd0);
    check_at(cyc + 6, "max_pre_idle", 4'b0000);
    cmd_at(cyc + 2, 1'b1, 1'b0, 16'hFFFF);
    repeat (300) begin
      @(posedge clk);
      #1;
    end
    chk("max_still_off", 64'(ena), 64'(0));
    chk("max_busy", 64'(busy), 64'(1));
    cmd_at(cyc + 1, 1'b0, 1'b1, 16'd0);
    chk("empty_abort_done", 64'(down_done), 64'(1));
    chk("empty_abort_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    chk("empty_abort_done_clr", 64'(down_done), 64'(0));

    // Randomized requests.
    repeat (9000) begin
      start = ($urandom_range(0, 11) == 0);
      stop  = ($urandom_range(0, 23) == 0);
      step_dly = ($urandom_range(0, 7) == 0) ? DLY_W'($urandom_range(5, 40))
                                             : DLY_W'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stop = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
